// File: rtl/bias_activate.sv
// bias_activate
//   Streams one LEN-element job: for each index it reads an accumulator
//   element and a bias element (both signed Q8.8), adds them, applies the
//   selected activation (ReLU or hard-tanh) and writes the result out with
//   a registered write strobe.
//
// Configuration macro:
//   BIAS_ACTIVATE_SAT_EN  defined   -> bias add saturates to 0x7FFF / 0x8000
//                         undefined -> bias add wraps (low 16 bits kept)
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      job request, sampled only while ready=1
//   act_sel    activation select, latched with start (0 ReLU, 1 hard-tanh)
//   acc_in     accumulator element at sel_acc (combinational read)
//   bias_in    bias element at sel_bias (combinational read)
//   sel_acc    accumulator read index
//   sel_bias   bias read index
//   data_out   registered activated result
//   out_sel    registered write index for data_out
//   out_write  write strobe qualifying data_out/out_sel
//   ready      FSM in IDLE
//   busy       FSM in RUN or DONE
//   done       one-cycle pulse in DONE (last write is visible alongside it)
//
// Handshake: start is a level request, not a valid/ready pair with
// back-pressure. It is accepted on a rising edge where ready=1 and start=1;
// any start seen while ready=0 is dropped. out_write is a pure strobe with
// no back-pressure: the consumer must take data_out/out_sel in the cycle
// out_write=1.
//
// The FSM state is fully decoded on ready/busy/done (IDLE = ready,
// RUN = busy & !done, DONE = done).
module bias_activate #(
  parameter int LEN      = 4,
  parameter int SEL_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                act_sel,
  input  logic [15:0]         acc_in,
  input  logic [15:0]         bias_in,
  output logic [SEL_BITS-1:0] sel_acc,
  output logic [SEL_BITS-1:0] sel_bias,
  output logic [15:0]         data_out,
  output logic [SEL_BITS-1:0] out_sel,
  output logic                out_write,
  output logic                ready,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(LEN - 1);

  state_e              state_q, state_d;
  logic [SEL_BITS-1:0] idx_q, idx_d;
  logic                act_q, act_d;
  logic [15:0]         data_q, data_d;
  logic [SEL_BITS-1:0] osel_q, osel_d;
  logic                wr_q, wr_d;

  // Bias add: 17-bit sign-extended sum, overflow when the two top bits differ.
  logic [16:0] sum17;
  logic        ovf;
  logic [15:0] sum16;
  logic [15:0] result;

  assign sum17 = {acc_in[15], acc_in} + {bias_in[15], bias_in};
  assign ovf   = sum17[16] ^ sum17[15];

  always_comb begin
    sum16 = sum17[15:0];
`ifdef BIAS_ACTIVATE_SAT_EN
    // The true sign of the sum is bit 16; clamp towards it on overflow.
    if (ovf) sum16 = sum17[16] ? 16'h8000 : 16'h7FFF;
`else
    if (ovf) sum16 = sum17[15:0];
`endif
  end

  always_comb begin
    result = sum16;
    if (act_q) begin
      // hard-tanh: clamp to [-1.0, +1.0] in Q8.8
      if ($signed(sum16) > $signed(16'h0100))      result = 16'h0100;
      else if ($signed(sum16) < $signed(16'hFF00)) result = 16'hFF00;
    end else begin
      // ReLU
      if (sum16[15]) result = 16'h0000;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    data_d  = data_q;
    osel_d  = osel_q;
    wr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          act_d   = act_sel;
        end
      end
      S_RUN: begin
        data_d = result;
        osel_d = idx_q;
        wr_d   = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      act_q   <= 1'b0;
      data_q  <= '0;
      osel_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      data_q  <= data_d;
      osel_q  <= osel_d;
      wr_q    <= wr_d;
    end
  end

  assign sel_acc   = idx_q;
  assign sel_bias  = idx_q;
  assign data_out  = data_q;
  assign out_sel   = osel_q;
  assign out_write = wr_q;
  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);

endmodule

// File: doc/bias_activate.md
BIAS_ACTIVATE -- requirements
Module: bias_activate

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning number of vector elements processed per job (2..256).
REQ-002 SHALL have parameter SEL_BITS, default 2, meaning width of all element indices; LEN <= 2**SEL_BITS.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, meaning job request; sampled only in IDLE.
REQ-006 SHALL have port act_sel, input, 1, meaning activation choice, sampled with start: 0 = ReLU, 1 = hard-tanh.
REQ-007 SHALL have port acc_in, input, 16, meaning signed Q8.8 accumulator element addressed by sel_acc, valid combinationally in the same cycle.
REQ-008 SHALL have port bias_in, input, 16, meaning signed Q8.8 bias element addressed by sel_bias, valid combinationally in the same cycle.
REQ-009 SHALL have port sel_acc, output, SEL_BITS, meaning read index into the upstream matmul result vector.
REQ-010 SHALL have port sel_bias, output, SEL_BITS, meaning read index into the bias vector.
REQ-011 SHALL have port data_out, output, 16, meaning activated Q8.8 result, registered.
REQ-012 SHALL have port out_sel, output, SEL_BITS, meaning write index for data_out, registered.
REQ-013 SHALL have port out_write, output, 1, meaning data_out/out_sel valid, write strobe to output vector.
REQ-014 SHALL have ports ready, busy, done, outputs, 1 each: ready = state IDLE; busy = state RUN or DONE; done = one-cycle pulse in DONE.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN when start=1; RUN->DONE after the RUN cycle with idx = LEN-1; DONE->IDLE unconditionally.
REQ-016 SHALL on IDLE->RUN clear idx to 0 and latch act_sel; start asserted outside IDLE SHALL be ignored, no queuing.
REQ-017 SHALL in each RUN cycle drive sel_acc = sel_bias = idx, then increment idx.
REQ-018 SHALL compute sum = acc_in + bias_in as 17-bit signed, reduced to 16 bits per REQ-027/028.
REQ-019 SHALL apply ReLU: result = 0 if sum < 0, else sum.
REQ-020 SHALL apply hard-tanh: result = clamp(sum, 0xFF00 (-1.0), 0x0100 (+1.0)).
REQ-021 SHALL register result into data_out, idx into out_sel, and set out_write=1 on the clock edge ending each RUN cycle; latency start-sample to first out_write = 2 cycles.
REQ-022 SHALL produce exactly LEN consecutive out_write pulses per job, out_sel 0..LEN-1 ascending; the last is visible in the DONE cycle together with done=1.
REQ-023 SHALL keep data_out and out_sel holding last values when out_write=0.
REQ-024 SHALL accept a new start in the IDLE cycle immediately after DONE (back-to-back jobs, one idle cycle between).

Reset
REQ-025 SHALL on rst=1 at a clock edge go to IDLE and set idx, sel_acc, sel_bias, out_sel, data_out to 0, and out_write, done, busy to 0, ready to 1, act_sel latch to 0.
REQ-026 SHALL on reset mid-job abort with no further out_write and no done pulse; rst has priority over start.

Configuration
REQ-027 SHALL, with macro BIAS_ACTIVATE_SAT_EN defined, saturate the bias add to 0x7FFF / 0x8000 on signed overflow before activation.
REQ-028 SHALL, without BIAS_ACTIVATE_SAT_EN, wrap the bias add (keep low 16 bits, two's complement) before activation.

Verification
REQ-029 ReLU, LEN=4: acc={0x0100,0xFE00,0x0080,0x0000}, bias={0x0080,0x0100,0xFF00,0x0000} -> writes idx0..3 = 0x0180,0x0000,0x0000,0x0000; done with idx3; first write 2 cycles after start.
REQ-030 Hard-tanh: acc={0x0300,0xFC00,0x0040,0xFFC0}, bias=0 -> 0x0100,0xFF00,0x0040,0xFFC0.
REQ-031 Overflow: acc=0x7F00, bias=0x0200, ReLU -> 0x7FFF with BIAS_ACTIVATE_SAT_EN; 0x0000 without (wrapped 0x8100 negative).
REQ-032 Start held high through a job -> only one job runs; next begins after one IDLE cycle following DONE; each job gives exactly 4 writes.
REQ-033 rst asserted in second RUN cycle -> next cycle ready=1, out_write=0, no done pulse; a fresh start then completes normally.
